mdu_sched: RTL and testbench
============================

# mdu_sched

Multiply/divide unit scheduler for the five-stage MIPS pipeline. It accepts HI/LO-class instructions issued from the E stage and runs mult/div for a fixed multi-cycle latency. It owns the architectural HI/LO registers and raises the D-stage stall for any HI/LO instruction while the unit is busy or starting. It sits alongside the E-stage ALU, is fed by the E-stage forwarded operands, and has its stall output ORed into the pipeline hazard stall.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd-class when enabled); legal range 1–15.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1–15.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; others = none.
- md_valid  in  1  E-stage instruction is valid.
- flush  in  1  exception/eret taken in M this cycle; the E-stage op must not take effect.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- d_uses_md  in  1  D-stage instruction is mult/div/madd-class/mfhi/mflo/mthi/mtlo.
- start  out  1  combinational; an arithmetic op is accepted this cycle.
- busy  out  1  registered; operation in flight.
- stall_md  out  1  combinational: d_uses_md & (start | busy).
- hi, lo  out  32 each  architectural HI/LO, registered.

## Operation
- FSM states: IDLE, MUL, DIV. Reset → IDLE with cnt=0, busy=0, hi=lo=0, pending result=0.
- Acceptance: an operation takes effect only if md_valid & !flush & state==IDLE. A valid op presented while busy is a protocol violation (stall_md prevents it) and is ignored.
- start = md_valid & !flush & IDLE & op∈{1,2,3,4,7–10}.
- mthi/mtlo (accepted): write a to hi/lo at the clock edge; no busy; in IDLE only.
- mult/multu: the 64-bit signed/unsigned product a*b is latched into the pending register; {hi,lo} receive it at completion.
- div/divu: lo = quotient, hi = remainder (signed ops truncate toward zero; remainder takes the sign of the dividend). When b==0, hi/lo are left unchanged at completion, but the busy time still elapses.
- Count: on start, the next state is MUL/DIV and cnt loads N−1 (N = MULT_CYCLES or DIV_CYCLES). The counter decrements each cycle. On the cycle with cnt==0, hi/lo commit at the edge and the next state is IDLE.
- flush does not affect an in-flight operation; it completes and commits.
- reset mid-operation: the op is abandoned, and hi/lo are forced to 0.

## Timing
- Start accepted in cycle T; busy=1 in cycles T+1 … T+N; new hi/lo are visible from T+N+1; busy=0 in T+N+1.
- mfhi/mflo in D: it is stalled in cycle T (via start) and T+1 … T+N, and reads the new value in D at T+N+1.
- A back-to-back HI/LO instruction can start at T+N+1 at the earliest.
- mthi/mtlo: the value is visible the cycle after acceptance; stall_md is not asserted for it.

## Configuration
- MDU_MADD_EN defined: ops 7–10 are legal and use MULT_CYCLES. At commit, {hi,lo} ← {hi,lo} ± product (signed for 7/9, unsigned for 8/10), modulo 2^64, using hi/lo as they are at commit time.
- MDU_MADD_EN undefined: ops 7–10 decode as none, with no start and no state change; the accumulate logic is absent.

## Structure
- The shared header holds the md_op encodings, the state encodings, and the default MULT_CYCLES/DIV_CYCLES values. The hazard unit and the E-stage decoder use the same encodings.
- One sub-module, mdu_core: combinational 64-bit product and quotient/remainder from (md_op, a, b). mdu_sched holds the FSM, the counter, the pending register and hi/lo.

## Test plan
- Reset → hi=lo=0, busy=0, stall_md=0; then mult a=0xFFFFFFFF, b=2 → busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu same operands → hi=0x00000001, lo=0xFFFFFFFE; d_uses_md held high → stall_md high from the start cycle through the last busy cycle, and low the next cycle.
- div a=−7, b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 with prior hi=1, lo=2 → hi/lo unchanged after 10 cycles.
- mult with flush=1 in the same cycle → start=0, busy stays 0, hi/lo unchanged. flush pulsed in mid-div → div still completes with the correct result.
- mthi a=0x12345678 → hi=0x12345678 the next cycle, no busy. Reset asserted at busy cycle 3 of mult → busy=0 and hi=lo=0 the next cycle, with no later commit.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu a=1, b=1 → hi=1, lo=0 after 5 cycles. Without the macro, the same op leaves busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_sched_pkg.sv
// Shared encodings for the multiply/divide scheduler: md_op codes, FSM states, default latencies.
// Ops 7-10 (madd-class) are decoded as arithmetic only when MDU_MADD_EN is defined.
package mdu_sched_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_arith(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_arith = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_arith = 1'b1;
`endif
      default: is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath: 64-bit product and 32-bit quotient/remainder for the current md_op.
// Signed division works on magnitudes so INT_MIN / -1 wraps instead of trapping.
module mdu_core
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic        mul_signed;
  logic        div_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] uq;
  logic [31:0] ur;

  assign mul_signed = (md_op == OP_MULT) || (md_op == OP_MADD) || (md_op == OP_MSUB);
  assign div_signed = (md_op == OP_DIV);

  assign a_ext = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign b_ext = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = a_ext * b_ext;

  assign a_mag  = (div_signed && a[31]) ? (32'd0 - a) : a;
  assign b_mag  = (div_signed && b[31]) ? (32'd0 - b) : b;
  // b==0 results are discarded by the scheduler; avoid a zero divisor anyway.
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq     = a_mag / b_safe;
  assign ur     = a_mag % b_safe;

  assign quot = (div_signed && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
  assign rem  = (div_signed && a[31]) ? (32'd0 - ur) : ur;

endmodule

// File: rtl/mdu_sched.sv
// HI/LO owner and multi-cycle mult/div scheduler with D-stage stall generation.
// Optional MDU_MADD_EN enables madd/maddu/msub/msubu accumulation into {hi,lo}.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        md_valid,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [63:0] pend_q;
  logic        skip_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef MDU_MADD_EN
  logic        acc_q;
  logic        sub_q;
`endif

  logic        accept;
  logic        is_div;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  mdu_core u_core (
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem)
  );

  assign accept   = md_valid && !flush && (state_q == ST_IDLE);
  assign start    = accept && is_arith(md_op);
  assign is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign stall_md = d_uses_md && (start || busy_q);
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      pend_q  <= 64'd0;
      skip_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= is_div ? ST_DIV : ST_MUL;
            cnt_q   <= is_div ? DIV_LOAD : MUL_LOAD;
            busy_q  <= 1'b1;
            pend_q  <= is_div ? {rem, quot} : prod;
            skip_q  <= is_div && (b == 32'd0);
`ifdef MDU_MADD_EN
            acc_q   <= (md_op == OP_MADD) || (md_op == OP_MADDU) ||
                       (md_op == OP_MSUB) || (md_op == OP_MSUBU);
            sub_q   <= (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
          end else if (accept && (md_op == OP_MTHI)) begin
            hi_q <= a;
          end else if (accept && (md_op == OP_MTLO)) begin
            lo_q <= a;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            // Accumulate uses hi/lo as they stand at commit, not at start.
`ifdef MDU_MADD_EN
            if (acc_q) begin
              {hi_q, lo_q} <= sub_q ? ({hi_q, lo_q} - pend_q) : ({hi_q, lo_q} + pend_q);
            end else if (!skip_q) begin
              {hi_q, lo_q} <= pend_q;
            end
`else
            if (!skip_q) begin
              {hi_q, lo_q} <= pend_q;
            end
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: directed cases plus randomized ops vs. an arithmetic model.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        md_valid;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_md;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_hilo = 64'd0;

  mdu_sched dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .md_valid  (md_valid),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .d_uses_md (d_uses_md),
    .start     (start),
    .busy      (busy),
    .stall_md  (stall_md),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic bit model_arith(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? 10 : 5;
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] cur);
    longint sx, sy, q, r;
    logic [63:0] sp, up, q64, r64;
    sx = $signed(x);
    sy = $signed(y);
    sp = sx * sy;
    up = {32'd0, x} * {32'd0, y};
    case (op)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (y == 32'd0) return cur;
        q = sx / sy; r = sx % sy;
        q64 = q; r64 = r;
        return {r64[31:0], q64[31:0]};
      end
      4'd4: begin
        if (y == 32'd0) return cur;
        return {x % y, x / y};
      end
      4'd7:  return cur + sp;
      4'd8:  return cur + up;
      4'd9:  return cur - sp;
      4'd10: return cur - up;
      default: return cur;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every commit the DUT presents.
  initial begin
    logic prev_busy = 1'b0;
    logic rst_pend  = 1'b0;
    logic mt_pend   = 1'b0;
    forever begin
      @(negedge clk);
      if ((mt_pend || (prev_busy && !busy)) && !rst_pend) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", {hi, lo}, model_hilo);
        end else begin
          chk("hilo_commit", {hi, lo}, exp_q.pop_front());
        end
      end
      prev_busy = busy;
      rst_pend  = reset;
      mt_pend   = md_valid && !flush && !busy && !reset && (md_op == 4'd5 || md_op == 4'd6);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; md_valid = 1'b0; flush = 1'b0; md_op = 4'd0; d_uses_md = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_hilo = 64'd0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic fl, input logic du);
    bit exp_start;
    bit bad_stall;
    int cycles;
    @(posedge clk); #1;
    md_op = op; a = av; b = bv; md_valid = 1'b1; flush = fl; d_uses_md = du;
    exp_start = model_arith(op) && !fl;
    #1;
    chk("start", {63'd0, start}, {63'd0, exp_start});
    chk("stall_start", {63'd0, stall_md}, {63'd0, du && exp_start});
    if (!fl) begin
      if (exp_start) begin
        model_hilo = ref_result(op, av, bv, model_hilo);
        exp_q.push_back(model_hilo);
      end else if (op == 4'd5) begin
        model_hilo = {av, model_hilo[31:0]};
        exp_q.push_back(model_hilo);
      end else if (op == 4'd6) begin
        model_hilo = {model_hilo[63:32], av};
        exp_q.push_back(model_hilo);
      end
    end
    @(posedge clk); #1;
    md_valid = 1'b0; flush = 1'b0; md_op = 4'd0;
    if (exp_start) begin
      cycles = 0;
      bad_stall = 1'b0;
      while (busy && cycles < 40) begin
        if (stall_md !== du) bad_stall = 1'b1;
        cycles++;
        @(posedge clk); #1;
      end
      chk("busy_cycles", 64'(cycles), 64'(model_lat(op)));
      chk("stall_while_busy", {63'd0, bad_stall}, 64'd0);
      chk("stall_after", {63'd0, stall_md}, 64'd0);
    end else begin
      chk("no_busy", {63'd0, busy}, 64'd0);
    end
    d_uses_md = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; md_op = 4'd0; md_valid = 1'b0; flush = 1'b0;
    a = 32'd0; b = 32'd0; d_uses_md = 1'b0;
    do_reset();
    d_uses_md = 1'b1; #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall_md}, 64'd0);

    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd5, 32'd1, 32'd0, 1'b0, 1'b0);
    issue(4'd6, 32'd2, 32'd0, 1'b0, 1'b0);
    issue(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("divu_by_zero", {hi, lo}, 64'h0000_0001_0000_0002);

    issue(4'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    chk("flushed_mult", {hi, lo}, 64'h0000_0001_0000_0002);

    // Flush pulse in the middle of a divide must not disturb it.
    fork
      issue(4'd3, 32'd100, 32'hFFFF_FFFD, 1'b0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk); #2 flush = 1'b0;
      end
    join

    issue(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
    chk("mthi_val", {32'd0, hi}, 64'h0000_0000_1234_5678);

    // Reset during busy cycle 3 of a mult abandons it.
    @(posedge clk); #1;
    md_op = 4'd1; a = 32'd9; b = 32'd9; md_valid = 1'b1;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_hilo = 64'd0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_commit", {hi, lo}, 64'd0);

    issue(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    issue(4'd8, 32'd1, 32'd1, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
    chk("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    chk("maddu_disabled", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 4'($urandom_range(0, 12));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      issue(rop, ra, rb, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("final_hilo", {hi, lo}, model_hilo);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
